sub_bytes_sched: RTL and testbench

SUB_BYTES_SCHED -- requirements
Module: sub_bytes_sched

---
 rtl/aes_pkg.sv | 17 +
 rtl/sbox_lane.sv | 33 +++
 rtl/sub_bytes_sched.sv | 152 +++++++++++++++
 tb/tb_sub_bytes_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the SubBytes/SubWord scheduler.
//   LaneCount : number of shared S-box lanes (bytes substituted per cycle)
//   BeatCount : cycles needed to push a 128-bit state through the lanes
//   sched_state_e : scheduler FSM states
package aes_pkg;

  localparam int unsigned LaneCount = 4;
  localparam int unsigned BeatCount = 4;
  localparam int unsigned CntWidth  = $clog2(BeatCount);

  typedef enum logic [1:0] {
    Idle,
    StRun,
    KwRun
  } sched_state_e;

endpackage

// File: rtl/sbox_lane.sv
// One combinational FIPS-197 forward S-box lane.
// Ports:
//   byte_in  : byte to substitute
//   byte_out : S-box image of byte_in
module sbox_lane (
  input  logic [7:0] byte_in,
  output logic [7:0] byte_out
);

  // Row r holds S-box entries 16r..16r+15; entry 0 sits in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // {~byte_in, 3'b000} == 8 * (255 - byte_in)
  assign byte_out = SboxTable[{~byte_in, 3'b000} +: 8];

endmodule

// File: rtl/sub_bytes_sched.sv
// Time-shares four S-box lanes between a 128-bit SubBytes requester (st_*) and a
// 32-bit SubWord requester (kw_*). A state takes four beats (one word per beat),
// a key word takes one beat. Arbitration happens only in Idle.
// Configuration: define SUB_BYTES_SCHED_RR_EN for round-robin arbitration; by
// default kw wins by fixed priority.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   st_valid/st_in      : state request;  st_ready : accepted this cycle
//   st_out/st_done      : substituted state; done pulses when st_out updates
//   kw_valid/kw_in      : word request;   kw_ready : accepted this cycle
//   kw_out/kw_done      : substituted word; done pulses when kw_out updates
//   busy                : FSM not Idle
module sub_bytes_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  input  logic [127:0] st_in,
  output logic         st_ready,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         kw_valid,
  input  logic [31:0]  kw_in,
  output logic         kw_ready,
  output logic [31:0]  kw_out,
  output logic         kw_done,
  output logic         busy
);

  sched_state_e        state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [127:0]        st_q, st_d;
  logic [31:0]         kw_q, kw_d;
  logic [127:0]        st_out_q, st_out_d;
  logic [31:0]         kw_out_q, kw_out_d;
  logic                st_done_q, st_done_d;
  logic                kw_done_q, kw_done_d;
  logic                idle, kw_grant, st_grant;
  logic [8*LaneCount-1:0] lane_in, lane_out;

  for (genvar i = 0; i < LaneCount; i++) begin : g_lane
    sbox_lane u_lane (
      .byte_in  (lane_in[8*i +: 8]),
      .byte_out (lane_out[8*i +: 8])
    );
  end

  // The state register rotates right one word per beat, so the lanes always
  // read its low word and the finished state ends up in original byte order.
  assign lane_in = (state_q == KwRun) ? kw_q : st_q[31:0];

  // Ready is a grant, so it is masked while reset is asserted.
  assign idle = (state_q == Idle) && rst_n;

`ifdef SUB_BYTES_SCHED_RR_EN
  logic last_kw_q, last_kw_d;
  // Contested cycle: the requester not granted last time wins.
  assign kw_grant = idle && kw_valid && (!st_valid || !last_kw_q);
`else
  assign kw_grant = idle && kw_valid;
`endif
  assign st_grant = idle && st_valid && !kw_grant;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    kw_d      = kw_q;
    st_out_d  = st_out_q;
    kw_out_d  = kw_out_q;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
`ifdef SUB_BYTES_SCHED_RR_EN
    last_kw_d = last_kw_q;
`endif
    unique case (state_q)
      Idle: begin
        if (kw_grant) begin
          kw_d    = kw_in;
          state_d = KwRun;
`ifdef SUB_BYTES_SCHED_RR_EN
          last_kw_d = 1'b1;
`endif
        end else if (st_grant) begin
          st_d    = st_in;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SUB_BYTES_SCHED_RR_EN
          last_kw_d = 1'b0;
`endif
        end
      end
      StRun: begin
        st_d  = {lane_out, st_q[127:32]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntWidth'(BeatCount - 1)) begin
          st_out_d  = {lane_out, st_q[127:32]};
          st_done_d = 1'b1;
          state_d   = Idle;
        end
      end
      KwRun: begin
        kw_out_d  = lane_out;
        kw_done_d = 1'b1;
        state_d   = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      st_q      <= '0;
      kw_q      <= '0;
      st_out_q  <= '0;
      kw_out_q  <= '0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      st_q      <= st_d;
      kw_q      <= kw_d;
      st_out_q  <= st_out_d;
      kw_out_q  <= kw_out_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
    end
  end

`ifdef SUB_BYTES_SCHED_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_kw_q <= 1'b0;
    end else begin
      last_kw_q <= last_kw_d;
    end
  end
`endif

  assign st_ready = st_grant;
  assign kw_ready = kw_grant;
  assign st_out   = st_out_q;
  assign kw_out   = kw_out_q;
  assign st_done  = st_done_q;
  assign kw_done  = kw_done_q;
  assign busy     = (state_q != Idle);

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Self-checking bench for sub_bytes_sched: directed vectors followed by random
// traffic, compared every cycle against a transaction-level model that computes
// the S-box from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         st_valid, kw_valid;
  logic [127:0] st_in;
  logic [31:0]  kw_in;
  logic         st_ready, st_done, kw_ready, kw_done, busy;
  logic [127:0] st_out;
  logic [31:0]  kw_out;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int           cyc = 0;
  int           free_at = 0;
  int           st_done_at = -1;
  int           kw_done_at = -1;
  logic [127:0] st_pend, st_exp;
  logic [31:0]  kw_pend, kw_exp;
  bit           last_kw = 1'b0;
  bit           known = 1'b0;

  always #5 clk = ~clk;

  sub_bytes_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_in    (st_in),
    .st_ready (st_ready),
    .st_out   (st_out),
    .st_done  (st_done),
    .kw_valid (kw_valid),
    .kw_in    (kw_in),
    .kw_ready (kw_ready),
    .kw_out   (kw_out),
    .kw_done  (kw_done),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    logic [7:0] s, t;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    s = r;
    t = r;
    for (int k = 0; k < 4; k++) begin
      t = {t[6:0], t[7]};
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(x[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_ref(x[8*i +: 8]);
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic rn, input logic sv, input logic [127:0] si,
                      input logic kv, input logic [31:0] ki);
    bit idle, kw_g, st_g;
    rst_n    = rn;
    st_valid = sv;
    st_in    = si;
    kw_valid = kv;
    kw_in    = ki;
    @(negedge clk);
    idle = rn && (cyc >= free_at);
`ifdef SUB_BYTES_SCHED_RR_EN
    kw_g = idle && kv && (!sv || !last_kw);
`else
    kw_g = idle && kv;
`endif
    st_g = idle && sv && !kw_g;
    check("st_ready", st_ready, st_g);
    check("kw_ready", kw_ready, kw_g);
    if (known) begin
      if (cyc == st_done_at) st_exp = st_pend;
      if (cyc == kw_done_at) kw_exp = kw_pend;
      check("st_done", st_done, cyc == st_done_at);
      check("kw_done", kw_done, cyc == kw_done_at);
      check("busy", busy, cyc < free_at);
      check("st_out", st_out, st_exp);
      check("kw_out", kw_out, kw_exp);
    end
    if (!rn) begin
      free_at    = cyc + 1;
      st_done_at = -1;
      kw_done_at = -1;
      st_exp     = '0;
      kw_exp     = '0;
      last_kw    = 1'b0;
      known      = 1'b1;
    end else if (kw_g) begin
      kw_pend    = sub_word(ki);
      kw_done_at = cyc + 2;
      free_at    = cyc + 2;
      last_kw    = 1'b1;
    end else if (st_g) begin
      st_pend    = sub_state(si);
      st_done_at = cyc + 5;
      free_at    = cyc + 5;
      last_kw    = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 128'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [127:0] rs;
    logic [31:0]  rk;
    bit           rv, kv, rn;

    // Reset
    step(1'b0, 1'b0, 128'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 128'h0, 1'b1, 32'h0);
    check("rst_st_out", st_out, 128'h0);
    check("rst_busy", busy, 1'b0);

    // All-zero state
    step(1'b1, 1'b1, 128'h0, 1'b0, 32'h0);
    idle_steps(5);
    check("vec_zero", st_out, {16{8'h63}});

    // Known SubBytes vector; input scrambled after acceptance
    step(1'b1, 1'b1, 128'h0848f8e92a8dc69a2be2f4a0bee33d19, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, {4{$urandom}}, 1'b0, 32'h0);
    check("vec_fips", st_out, 128'h3052411ee55db4b8f198bfe0ae1127d4);

    // Known SubWord vector
    step(1'b1, 1'b0, 128'h0, 1'b1, 32'hcf4f3c09);
    idle_steps(2);
    check("vec_kw", kw_out, 32'h8a84eb01);
    check("vec_kw_st_hold", st_out, 128'h3052411ee55db4b8f198bfe0ae1127d4);

    // Contention: both requesters held valid
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, {4{$urandom}}, 1'b1, $urandom);
    idle_steps(6);

    // Reset during beat 2 of a state job
    step(1'b1, 1'b1, {4{$urandom}}, 1'b0, 32'h0);
    idle_steps(2);
    step(1'b0, 1'b0, 128'h0, 1'b0, 32'h0);
    idle_steps(4);
    check("abort_st_out", st_out, 128'h0);
    check("abort_busy", busy, 1'b0);
    step(1'b1, 1'b1, 128'h0, 1'b0, 32'h0);
    idle_steps(5);
    check("abort_recover", st_out, {16{8'h63}});

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 79) != 0);
      rv = $urandom_range(0, 1) == 1;
      kv = $urandom_range(0, 2) == 0;
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = $urandom;
      step(rn, rv, rs, kv, rk);
    end
    idle_steps(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
